// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial wide adder sequencer:
// FSM state encoding, the datapath byte width and the byte-index width helper.
package add_seq_pkg;

    // Width of the single time-multiplexed adder slice
    localparam int BYTE_W = 8;

    // Sequencer states; explicit encodings keep the register image stable
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index width: enough bits to address NBYTES bytes, never narrower than 1
    function automatic int idx_width(input int nbytes);
        if (nbytes <= 1) begin
            return 1;
        end else begin
            return $clog2(nbytes);
        end
    endfunction

endpackage

// File: rtl/byte_serial_adder_ctrl_carry_adder.sv
// CarryAdder: the existing 8-bit ripple-carry adder slice.
// Purely combinational; the sequencer reuses one instance for every byte.
module CarryAdder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [8:0] carry_s;

    // Ripple the carry bit by bit from cin to the top of the slice
    always_comb begin
        carry_s    = 9'd0;
        s          = 8'd0;
        carry_s[0] = cin;
        for (int i = 0; i < 8; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_s[8];

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// byte_serial_adder_ctrl: performs an NBYTES x 8-bit addition by feeding one
// byte per clock (LSB first) through a single 8-bit CarryAdder, with the
// carry registered between bytes. Valid/ready handshakes on both sides.
// Optional feature macro: ADD_SEQ_SUB_EN adds the 'op' port (1 = a - b,
// implemented as a + ~b + 1; cout = 1 means no borrow).
module byte_serial_adder_ctrl
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*NBYTES-1:0]     a,
    input  logic [8*NBYTES-1:0]     b,
    input  logic                    cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                    op,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*NBYTES-1:0]     sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int                 IDX_W    = idx_width(NBYTES);
    localparam int                 W        = BYTE_W * NBYTES;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic               out_valid_r;

    logic               accept_s;
    logic [W-1:0]       b_load_s;
    logic               cin_load_s;
    logic [7:0]         add_a_s;
    logic [7:0]         add_b_s;
    logic [7:0]         add_sum_s;
    logic               add_cout_s;

    assign accept_s = in_valid && (state_r == IDLE);

    // Condition operand B and the initial carry for add or subtract at capture time
    always_comb begin
        b_load_s   = b;
        cin_load_s = cin;
`ifdef ADD_SEQ_SUB_EN
        if (op) begin
            b_load_s   = ~b;
            cin_load_s = 1'b1;
        end else begin
            b_load_s   = b;
            cin_load_s = cin;
        end
`endif
    end

    // Select the current byte of each captured operand for the shared adder
    always_comb begin
        add_a_s = a_r[int'(idx_r) * BYTE_W +: BYTE_W];
        add_b_s = b_r[int'(idx_r) * BYTE_W +: BYTE_W];
    end

    CarryAdder u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (carry_r),
        .s    (add_sum_s),
        .cout (add_cout_s)
    );

    // Sequencer: capture in IDLE, one byte per cycle in RUN, hold result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= b_load_s;
                        carry_r <= cin_load_s;
                        idx_r   <= '0;
                        sum_r   <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[int'(idx_r) * BYTE_W +: BYTE_W] <= add_sum_s;
                    carry_r <= add_cout_s;
                    if (idx_r == LAST_IDX) begin
                        // Last byte written: the index stays put, no wrap needed
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + 1'b1;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = carry_r;

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed bench for byte_serial_adder_ctrl (NBYTES=4) with a scoreboard queue.
// Build with ADD_SEQ_SUB_EN defined to also exercise subtraction.
module tb_byte_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef ADD_SEQ_SUB_EN
    logic         op;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int           nchecks = 0;
    int           nerrs   = 0;
    logic [W:0]   exp_q[$];

    always #5 clk = ~clk;

    byte_serial_adder_ctrl #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] expv);
        nchecks++;
        assert (obs === expv) else begin
            nerrs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE for one accept edge and record the expected result
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv);
        int         n;
        logic [W:0] e;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_wait", (W+1)'(in_ready), (W+1)'(1'b1));
        a   = av;
        b   = bv;
        cin = cv;
`ifdef ADD_SEQ_SUB_EN
        op  = sv;
`endif
        if (sv) begin
            e = {1'b0, av} + {1'b0, ~bv} + {{W{1'b0}}, 1'b1};
        end else begin
            e = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        end
        exp_q.push_back(e);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat is the cycle index relative to accept
    task automatic wait_valid(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, (W+1)'(out_valid), (W+1)'(1'b1));
    endtask

    task automatic pop_compare(input string tag, output logic [W:0] e);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = 'x;
        end
        check({tag, "_sum"},  (W+1)'(sum),  (W+1)'(e[W-1:0]));
        check({tag, "_cout"}, (W+1)'(cout), (W+1)'(e[W]));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ready_after"}, (W+1)'(in_ready),  (W+1)'(1'b1));
        check({tag, "_valid_after"}, (W+1)'(out_valid), (W+1)'(1'b0));
    endtask

    initial begin
        int         lat;
        logic [W:0] e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        op        = 1'b0;
`endif
        repeat (3) tick();
        check("rst_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b1));
        check("rst_out_valid", (W+1)'(out_valid), (W+1)'(1'b0));
        check("rst_busy",      (W+1)'(busy),      (W+1)'(1'b0));
        check("rst_sum",       (W+1)'(sum),       (W+1)'(0));
        check("rst_cout",      (W+1)'(cout),      (W+1)'(1'b0));
        rst_n = 1'b1;
        tick();

        // Byte carry into byte 1, latency measurement
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        check("t1_busy",     (W+1)'(busy),     (W+1)'(1'b1));
        check("t1_in_ready", (W+1)'(in_ready), (W+1)'(1'b0));
        wait_valid("t1", lat);
        check("t1_latency", (W+1)'(lat), (W+1)'(5));
        pop_compare("t1", e);
        consume("t1");

        // Carry ripples through all four bytes
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_valid("t2", lat);
        pop_compare("t2", e);
        consume("t2");

        // Backpressure with a stray in_valid while the result is held
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        wait_valid("t3", lat);
        pop_compare("t3", e);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 32'h0000_0001;
            b        = 32'h0000_0001;
            cin      = 1'b0;
            tick();
            check("t3_hold_valid", (W+1)'(out_valid), (W+1)'(1'b1));
            check("t3_hold_ready", (W+1)'(in_ready),  (W+1)'(1'b0));
            check("t3_hold_sum",   (W+1)'(sum),       (W+1)'(e[W-1:0]));
            check("t3_hold_cout",  (W+1)'(cout),      (W+1)'(e[W]));
        end
        in_valid = 1'b0;
        consume("t3");
        tick();
        tick();
        check("t3_no_capture_busy",  (W+1)'(busy),      (W+1)'(1'b0));
        check("t3_no_capture_valid", (W+1)'(out_valid), (W+1)'(1'b0));

        // Asynchronous reset while byte 2 is being processed
        send(32'h1111_1111, 32'h1111_1111, 1'b0, 1'b0);
        tick();
        tick();
        check("t4_partial_sum", (W+1)'(sum), (W+1)'(32'h0000_2222));
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("t4_rst_valid", (W+1)'(out_valid), (W+1)'(1'b0));
        check("t4_rst_sum",   (W+1)'(sum),       (W+1)'(0));
        check("t4_rst_cout",  (W+1)'(cout),      (W+1)'(1'b0));
        check("t4_rst_busy",  (W+1)'(busy),      (W+1)'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        send(32'h0000_0012, 32'h0000_0034, 1'b0, 1'b0);
        wait_valid("t4", lat);
        pop_compare("t4", e);
        check("t4_sum_const", (W+1)'(sum), (W+1)'(32'h0000_0046));
        consume("t4");

        // A few random additions, issued back to back
        for (int k = 0; k < 4; k++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 1'b0);
            wait_valid("rnd", lat);
            check("rnd_latency", (W+1)'(lat), (W+1)'(5));
            pop_compare("rnd", e);
            consume("rnd");
        end

`ifdef ADD_SEQ_SUB_EN
        // Subtraction: cin is ignored, cout=1 means no borrow
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
        wait_valid("sub1", lat);
        pop_compare("sub1", e);
        check("sub1_sum_const", (W+1)'({cout, sum}), {1'b0, 32'hFFFF_FFF0});
        consume("sub1");
        send(32'h0000_0020, 32'h0000_0010, 1'b0, 1'b1);
        wait_valid("sub2", lat);
        pop_compare("sub2", e);
        check("sub2_sum_const", (W+1)'({cout, sum}), {1'b1, 32'h0000_0010});
        consume("sub2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
